// File: rtl/bp_mac_seq.sv
// -----------------------------------------------------------------------------
// bp_mac_seq
//   Sequencer for the MAC section of the LSTM backpropagation datapath.
//   Walks dX2 (mode 0), dOut2 (mode 1) or dOut1 (mode 2) one output row at a
//   time. For every row it clears the MAC, then issues 4 gates x COLS columns
//   of weight reads, waits for the read pipeline and the MAC output register
//   to drain, and writes the accumulated result to the destination memory.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   i_start, i_mode     start request (sampled in IDLE) and operation select
//   i_hold              stall: freezes everything, masks pulse outputs
//   o_busy, o_done      operation in progress / one-cycle completion pulse
//   o_row, o_col        weight-memory row/column of the term being issued
//   o_sel_*             gate/path selects, delayed to line up with weight data
//   o_acc_mac           MAC accumulate enable (aligned with weight data)
//   o_rst_mac           MAC clear, active-low
//   o_wr_dx2/dout2/dout1, o_wr_addr   destination write strobe and address
// -----------------------------------------------------------------------------
module bp_mac_seq #(
    parameter int LAYR1_CELL = 53,
    parameter int LAYR2_CELL = 8,
    parameter int RD_LAT     = 1,
    parameter int ADDR       = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [1:0]      i_mode,
    input  logic            i_hold,
    output logic            o_busy,
    output logic            o_done,
    output logic [ADDR-1:0] o_row,
    output logic [ADDR-1:0] o_col,
    output logic [1:0]      o_sel_dgate,
    output logic            o_sel_wght,
    output logic [1:0]      o_sel_wghts1,
    output logic [2:0]      o_sel_wghts2,
    output logic            o_acc_mac,
    output logic            o_rst_mac,
    output logic            o_wr_dx2,
    output logic            o_wr_dout2,
    output logic            o_wr_dout1,
    output logic [ADDR-1:0] o_wr_addr
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_RUN, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    localparam logic [1:0] MODE_DX2   = 2'd0;
    localparam logic [1:0] MODE_DOUT2 = 2'd1;
    localparam logic [1:0] MODE_DOUT1 = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    state_t          state_q;
    logic [1:0]      mode_q;
    logic [ADDR-1:0] row_q;
    logic [ADDR-1:0] j_q;
    logic [1:0]      g_q;
    logic [2:0]      drain_q;
    logic            busy_q;
    logic            done_q;
    logic            rst_mac_q;
    logic [2:0]      wr_q;        // one-hot {dout1, dout2, dx2}

    // Row/column limits of the latched operation
    logic [ADDR-1:0] rows_m1;
    logic [ADDR-1:0] cols_m1;

    always_comb begin
        rows_m1 = (mode_q == MODE_DOUT2) ? ADDR'(LAYR2_CELL - 1) : ADDR'(LAYR1_CELL - 1);
        cols_m1 = (mode_q == MODE_DOUT1) ? ADDR'(LAYR1_CELL - 1) : ADDR'(LAYR2_CELL - 1);
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered strobes
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            mode_q    <= MODE_DX2;
            row_q     <= '0;
            j_q       <= '0;
            g_q       <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rst_mac_q <= 1'b1;
            wr_q      <= '0;
        end else if (!i_hold) begin
            case (state_q)
                S_IDLE: begin
                    if (i_start && (i_mode != MODE_RSVD)) begin
                        mode_q    <= i_mode;
                        row_q     <= '0;
                        j_q       <= '0;
                        g_q       <= '0;
                        busy_q    <= 1'b1;
                        rst_mac_q <= 1'b0;
                        state_q   <= S_CLR;
                    end
                end
                S_CLR: begin
                    rst_mac_q <= 1'b1;
                    j_q       <= '0;
                    g_q       <= '0;
                    state_q   <= S_RUN;
                end
                S_RUN: begin
                    if (j_q == cols_m1) begin
                        j_q <= '0;
                        g_q <= g_q + 2'd1;
                        if (g_q == 2'd3) begin
                            drain_q <= '0;
                            state_q <= S_DRAIN;
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // RD_LAT cycles flush the read pipeline, one more for the MAC register
                    if (drain_q == 3'(RD_LAT)) begin
                        wr_q    <= 3'(3'b001 << mode_q);
                        state_q <= S_WRITE;
                    end else begin
                        drain_q <= drain_q + 3'd1;
                    end
                end
                S_WRITE: begin
                    wr_q <= '0;
                    if (row_q == rows_m1) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        row_q     <= row_q + 1'b1;
                        rst_mac_q <= 1'b0;
                        state_q   <= S_CLR;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Issue pipeline: RD_LAT stages carrying issue-valid, gate and path bits so
    // the accumulate enable and selects arrive together with the weight data.
    // Data fields only load on a valid entry, so the selects hold their last
    // value between rows.
    // -------------------------------------------------------------------------
    logic [RD_LAT:0]       v_chain;
    logic [2*RD_LAT+1:0]   gate_chain;
    logic [RD_LAT:0]       wght_chain;
    logic [RD_LAT:0]       u_chain;

    assign v_chain[0]       = (state_q == S_RUN);
    assign gate_chain[1:0]  = g_q;
    assign wght_chain[0]    = (mode_q == MODE_DOUT1);
    assign u_chain[0]       = (mode_q == MODE_DOUT2);

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_sr
            logic       v_q;
            logic [1:0] gate_q;
            logic       wght_q;
            logic       u_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v_q    <= 1'b0;
                    gate_q <= '0;
                    wght_q <= 1'b0;
                    u_q    <= 1'b0;
                end else if (!i_hold) begin
                    v_q <= v_chain[gi];
                    if (v_chain[gi]) begin
                        gate_q <= gate_chain[2*gi +: 2];
                        wght_q <= wght_chain[gi];
                        u_q    <= u_chain[gi];
                    end
                end
            end

            assign v_chain[gi+1]           = v_q;
            assign gate_chain[2*gi+2 +: 2] = gate_q;
            assign wght_chain[gi+1]        = wght_q;
            assign u_chain[gi+1]           = u_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs; hold masks every pulse without disturbing the stored value
    // -------------------------------------------------------------------------
    assign o_busy       = busy_q;
    assign o_done       = done_q & ~i_hold;
    assign o_row        = row_q;
    assign o_col        = j_q;
    assign o_wr_addr    = row_q;
    assign o_rst_mac    = rst_mac_q | i_hold;
    assign o_acc_mac    = v_chain[RD_LAT] & ~i_hold;
    assign o_wr_dx2     = wr_q[0] & ~i_hold;
    assign o_wr_dout2   = wr_q[1] & ~i_hold;
    assign o_wr_dout1   = wr_q[2] & ~i_hold;
    assign o_sel_dgate  = gate_chain[2*RD_LAT +: 2];
    assign o_sel_wghts1 = gate_chain[2*RD_LAT +: 2];
    assign o_sel_wght   = wght_chain[RD_LAT];
    assign o_sel_wghts2 = {u_chain[RD_LAT], gate_chain[2*RD_LAT +: 2]};

endmodule

// File: tb/tb_bp_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_bp_mac_seq
//   Self-checking bench for bp_mac_seq. Expected destination writes are queued
//   when a start is driven and popped by a negedge monitor whenever a write
//   strobe appears; the monitor also checks select alignment on every
//   accumulate and the hold/exclusivity rules on every cycle.
// -----------------------------------------------------------------------------
module tb_bp_mac_seq;

    localparam int L1  = 53;
    localparam int L2  = 8;
    localparam int RDL = 1;
    localparam int AW  = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start = 1'b0;
    logic [1:0]    i_mode = 2'd0;
    logic          i_hold = 1'b0;
    logic          o_busy, o_done, o_sel_wght, o_acc_mac, o_rst_mac;
    logic          o_wr_dx2, o_wr_dout2, o_wr_dout1;
    logic [AW-1:0] o_row, o_col, o_wr_addr;
    logic [1:0]    o_sel_dgate, o_sel_wghts1;
    logic [2:0]    o_sel_wghts2;

    bp_mac_seq #(
        .LAYR1_CELL(L1), .LAYR2_CELL(L2), .RD_LAT(RDL), .ADDR(AW)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_hold(i_hold),
        .o_busy(o_busy), .o_done(o_done), .o_row(o_row), .o_col(o_col),
        .o_sel_dgate(o_sel_dgate), .o_sel_wght(o_sel_wght),
        .o_sel_wghts1(o_sel_wghts1), .o_sel_wghts2(o_sel_wghts2),
        .o_acc_mac(o_acc_mac), .o_rst_mac(o_rst_mac),
        .o_wr_dx2(o_wr_dx2), .o_wr_dout2(o_wr_dout2), .o_wr_dout1(o_wr_dout1),
        .o_wr_addr(o_wr_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int kind;   // 0=dx2 1=dout2 2=dout1
        int addr;
    } wr_t;

    wr_t sb_q[$];
    int  cur_mode   = 0;
    int  acc_in_row = 0;
    int  prev_col   = 0;
    int  done_cnt   = 0;

    // -------------------------------------------------------------------------
    // Monitor: sampled on the falling edge
    // -------------------------------------------------------------------------
    always @(negedge clk) begin : mon
        int  cols;
        int  nwr;
        int  gate_e;
        int  kind;
        wr_t exp_w;
        cols = (cur_mode == 2) ? L1 : L2;
        nwr  = int'(o_wr_dx2) + int'(o_wr_dout2) + int'(o_wr_dout1);
        if (!rst) begin
            acc_in_row = 0;
            prev_col   = 0;
        end else begin
            if (nwr != 0) check_val("one_strobe", nwr, 1);
            if (o_acc_mac) check_val("acc_vs_clr", int'(o_rst_mac), 1);
            if (i_hold) begin
                check_val("hold_acc", int'(o_acc_mac), 0);
                check_val("hold_wr", nwr, 0);
                check_val("hold_done", int'(o_done), 0);
                check_val("hold_rstmac", int'(o_rst_mac), 1);
            end else begin
                if (!o_rst_mac) acc_in_row = 0;
                if (o_acc_mac) begin
                    gate_e = acc_in_row / cols;
                    check_val("sel_dgate", int'(o_sel_dgate), gate_e);
                    check_val("acc_col", prev_col, acc_in_row % cols);
                    check_val("sel_wght", int'(o_sel_wght), (cur_mode == 2) ? 1 : 0);
                    if (cur_mode == 2)
                        check_val("sel_wghts1", int'(o_sel_wghts1), gate_e);
                    else
                        check_val("sel_wghts2", int'(o_sel_wghts2), ((cur_mode == 1) ? 4 : 0) + gate_e);
                    acc_in_row++;
                end
                if (nwr != 0) begin
                    kind = o_wr_dx2 ? 0 : (o_wr_dout2 ? 1 : 2);
                    if (sb_q.size() == 0) begin
                        check_val("sb_underflow", 1, 0);
                    end else begin
                        exp_w = sb_q.pop_front();
                        check_val("wr_kind", kind, exp_w.kind);
                        check_val("wr_addr", int'(o_wr_addr), exp_w.addr);
                        check_val("acc_per_row", acc_in_row, 4 * cols);
                    end
                end
                if (o_done) done_cnt++;
                prev_col = int'(o_col);
            end
        end
    end

    // -------------------------------------------------------------------------
    // One complete operation. Cycle 1 is the cycle after the accepted start edge.
    // -------------------------------------------------------------------------
    task automatic run_mode(input int mode, input int hold_at, input int bstart_at,
                            input int exp_done, input int exp_first_wr);
        int rows;
        int cyc;
        int first_wr;
        int d0;
        bit got;
        rows     = (mode == 1) ? L2 : L1;
        cur_mode = mode;
        for (int r = 0; r < rows; r++) sb_q.push_back('{mode, r});
        d0 = done_cnt;
        @(posedge clk); #1;
        i_start = 1'b1;
        i_mode  = 2'(mode);
        @(posedge clk); #1;
        i_start  = 1'b0;
        cyc      = 1;
        first_wr = 0;
        got      = 1'b0;
        check_val("busy_start", int'(o_busy), 1);
        while (!got && cyc < 20000) begin
            if (o_done) begin
                got = 1'b1;
            end else begin
                if (first_wr == 0 && (o_wr_dx2 || o_wr_dout2 || o_wr_dout1)) first_wr = cyc;
                if (cyc == hold_at) i_hold = 1'b1;
                if (cyc == hold_at + 10) i_hold = 1'b0;
                if (cyc == bstart_at) begin
                    i_start = 1'b1;
                    i_mode  = 2'd0;
                end else begin
                    i_start = 1'b0;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        i_hold  = 1'b0;
        i_start = 1'b0;
        check_val($sformatf("done_cycle_m%0d", mode), got ? cyc : -1, exp_done);
        check_val("busy_at_done", int'(o_busy), 1);
        if (exp_first_wr > 0) check_val("first_wr_cycle", first_wr, exp_first_wr);
        @(posedge clk); #1;
        check_val("busy_after_done", int'(o_busy), 0);
        check_val("done_pulse_len", int'(o_done), 0);
        check_val("done_count", done_cnt - d0, 1);
        check_val("sb_left", sb_q.size(), 0);
        $display("run mode=%0d hold_at=%0d busy_start_at=%0d done_cycle=%0d", mode, hold_at, bstart_at, cyc);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_busy"}, int'(o_busy), 0);
        check_val({pfx, "_done"}, int'(o_done), 0);
        check_val({pfx, "_rstmac"}, int'(o_rst_mac), 1);
        check_val({pfx, "_acc"}, int'(o_acc_mac), 0);
        check_val({pfx, "_wr"}, int'(o_wr_dx2) + int'(o_wr_dout2) + int'(o_wr_dout1), 0);
        check_val({pfx, "_row"}, int'(o_row), 0);
        check_val({pfx, "_col"}, int'(o_col), 0);
        check_val({pfx, "_wraddr"}, int'(o_wr_addr), 0);
        check_val({pfx, "_wghts2"}, int'(o_sel_wghts2), 0);
        check_val({pfx, "_wght"}, int'(o_sel_wght), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int d0;
        int n;
        bit busy_seen;

        // Reset state
        #12;
        check_reset_outputs("reset");
        $display("reset state checked");
        @(posedge clk); #1;
        rst = 1'b1;

        // Mode 1 plain, then with a start while busy, then with a 10-cycle hold
        run_mode(1, 0, 0, 289, 36);
        run_mode(1, 0, 50, 289, 0);
        run_mode(1, 100, 0, 299, 0);

        // Reserved mode: start ignored
        d0 = done_cnt;
        @(posedge clk); #1;
        i_start = 1'b1;
        i_mode  = 2'd3;
        @(posedge clk); #1;
        i_start = 1'b0;
        busy_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (o_busy) busy_seen = 1'b1;
            @(posedge clk); #1;
        end
        check_val("mode3_busy", int'(busy_seen), 0);
        check_val("mode3_done", done_cnt - d0, 0);
        $display("mode 3 start busy_seen=%0d", busy_seen);

        // Mode 0 and mode 2 full runs
        run_mode(0, 0, 0, 1909, 36);
        run_mode(2, 0, 0, 11449, 216);

        // Asynchronous reset mid-RUN at mode 0, row 5
        cur_mode = 0;
        for (int r = 0; r < L1; r++) sb_q.push_back('{0, r});
        @(posedge clk); #1;
        i_start = 1'b1;
        i_mode  = 2'd0;
        @(posedge clk); #1;
        i_start = 1'b0;
        n = 0;
        while (!(o_row == AW'(5) && o_acc_mac) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("reach_row5", int'(o_row), 5);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb_q.delete();
        $display("reset asserted mid-run at row 5 after %0d cycles", n);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        run_mode(1, 0, 0, 289, 36);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
